frame_encoder: RTL and testbench
================================

# frame_encoder

Writes the four sprite bitmaps (player1, player2, bullet1, bullet2) into external SRAM before a match. It is the write-side counterpart of FrameDecoder. It pulls 24-bit colour plus alpha pixels from a sprite source over a valid/ready handshake, packs each pixel to RGB565 and drives the SRAM write port (address, data, write strobe) that top muxes against the decoder. In the same cycle as each write it publishes per-pixel opacity, object ID and row/column, so top can build the opacity masks.

## Interface
- PLAYER_SIZE, 32, player sprite edge in pixels (sprite is square)
- BULLET_SIZE, 8, bullet sprite edge in pixels
- BASE_ADDR, 0, SRAM word address of player1 pixel 0
- ADDR_W, 20, SRAM address width
- DATA_W, 16, SRAM data width
- CNT_W, $clog2(PLAYER_SIZE*PLAYER_SIZE), pixel index width
- XY_W, $clog2(PLAYER_SIZE), row/column width
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  one-cycle request to encode all four sprites
- o_busy  out  1  high from accepted start to done
- o_done  out  1  one-cycle pulse after the last write
- o_object_id  out  2  sprite being encoded: 0=player1, 1=player2, 2=bullet1, 3=bullet2
- o_pixel_counter  out  CNT_W  pixel index within the current sprite, row-major
- o_pixel_h  out  XY_W  column of the current pixel
- o_pixel_v  out  XY_W  row of the current pixel
- o_src_ready  out  1  encoder can accept a pixel
- i_src_valid  in  1  source pixel valid
- i_src_color  in  24  {R[7:0],G[7:0],B[7:0]}
- i_src_alpha  in  1  1 = opaque
- o_sram_writing  out  1  write strobe; top drives WE_N = !o_sram_writing
- o_sram_addr  out  ADDR_W  write address
- o_sram_data  out  DATA_W  write data
- o_pixel_opacity  out  1  alpha of the pixel being written
- o_pixel_opacity_valid  out  1  high exactly in write cycles

## Operation
- The FSM has four states: IDLE, FETCH, WRITE, DONE.
- IDLE: all strobes are low. If i_start is high, the FSM clears object/pixel/row/column to 0, sets o_busy and moves to FETCH.
- FETCH: o_src_ready=1. o_object_id, o_pixel_counter, o_pixel_h and o_pixel_v address the source ROM.
  - On i_src_valid, the encoder latches colour and alpha and moves to WRITE.
  - Otherwise it holds with no change.
- WRITE: lasts one cycle, with o_sram_writing=1 and o_pixel_opacity_valid=1.
  - o_sram_data = {R[7:3],G[7:2],B[7:3]}.
  - o_sram_addr = base(obj) + pixel_counter.
  - Sprite bases:
    - player1: BASE_ADDR.
    - player2: +PLAYER_SIZE².
    - bullet1: +2·PLAYER_SIZE².
    - bullet2: +2·PLAYER_SIZE²+BULLET_SIZE².
  - Counters advance at the end of WRITE. The column increments; when it reaches size(obj)−1 it wraps to 0 and the row increments. pixel_counter increments.
  - After the last pixel of a sprite (pixel_counter = size²−1), the object increments and pixel/row/column clear.
  - After the last bullet2 pixel the FSM goes to DONE; otherwise it returns to FETCH.
- DONE: o_done=1 for one cycle, o_busy drops, then IDLE.
- i_start is ignored in every state except IDLE.
- Row/column counters are maintained incrementally; no divider or modulo logic.
- Transparent pixels are still written. Opacity is carried only on o_pixel_opacity.

## Timing
- Reset (async): state=IDLE; every output is 0, including o_object_id, counters, o_sram_addr and o_sram_data.
- Reset asserted mid-encode aborts immediately. There is no done pulse, and SRAM content is left partial.
- Start to first o_src_ready: 1 cycle (start sampled in IDLE, FETCH on the next edge).
- A source handshake in cycle n produces the write in cycle n+1. Peak throughput is 1 pixel per 2 cycles.
- o_sram_addr, o_sram_data, o_object_id, o_pixel_h/v and o_pixel_counter are registered and stable for the whole WRITE cycle.
- o_sram_writing is never high outside WRITE, so the decoder owns the bus in every other cycle.
- The last WRITE is followed by o_done on the next cycle. Total minimum duration = 2·(2·PLAYER_SIZE²+2·BULLET_SIZE²)+2 cycles.

## Test plan
- Defaults, source always valid, start pulse -> 2176 write cycles. Addresses are 0..2175, each seen once in order. o_done pulses once, 4354 cycles after the start edge.
- Colour 0xFF8040, alpha 1, at player1 pixel 0 -> write with addr 0, data 0xFC08, o_pixel_opacity=1.
- Boundary checks, each with h/v/counter at the stated values:
  - First bullet1 pixel -> addr 2048, object 2, h=v=0, counter 0.
  - Player1 pixel 33 -> h=1, v=1.
  - Bullet2 last pixel -> addr 2175, h=v=7.
- i_src_valid held low for 5 cycles mid-sprite -> o_src_ready stays 1, no write, counters frozen. Resume -> next address is consecutive.
- i_start pulsed while busy -> no restart, count and order unchanged. i_start in IDLE after done -> new full sequence from addr 0.
- i_rst_n low during player2 -> all outputs 0 asynchronously. After release, stays IDLE until i_start, with no o_done pulse.

Source files
------------

// File: rtl/frame_encoder.sv
// frame_encoder: streams four sprite bitmaps from a valid/ready pixel source
// into SRAM as RGB565, one write per accepted pixel, and publishes per-pixel
// opacity, object ID and row/column alongside each write.
`timescale 1ns/1ps
module frame_encoder #(
   parameter int PLAYER_SIZE = 32,
   parameter int BULLET_SIZE = 8,
   parameter int BASE_ADDR   = 0,
   parameter int ADDR_W      = 20,
   parameter int DATA_W      = 16,
   parameter int CNT_W       = $clog2(PLAYER_SIZE*PLAYER_SIZE),
   parameter int XY_W        = $clog2(PLAYER_SIZE)
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   output logic              o_busy,
   output logic              o_done,
   output logic [1:0]        o_object_id,
   output logic [CNT_W-1:0]  o_pixel_counter,
   output logic [XY_W-1:0]   o_pixel_h,
   output logic [XY_W-1:0]   o_pixel_v,
   output logic              o_src_ready,
   input  logic              i_src_valid,
   input  logic [23:0]       i_src_color,
   input  logic              i_src_alpha,
   output logic              o_sram_writing,
   output logic [ADDR_W-1:0] o_sram_addr,
   output logic [DATA_W-1:0] o_sram_data,
   output logic              o_pixel_opacity,
   output logic              o_pixel_opacity_valid
);

   typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;

   localparam int P_PIX = PLAYER_SIZE * PLAYER_SIZE;
   localparam int B_PIX = BULLET_SIZE * BULLET_SIZE;

   localparam logic [CNT_W-1:0]  P_LAST = CNT_W'(P_PIX - 1);
   localparam logic [CNT_W-1:0]  B_LAST = CNT_W'(B_PIX - 1);
   localparam logic [XY_W-1:0]   P_EDGE = XY_W'(PLAYER_SIZE - 1);
   localparam logic [XY_W-1:0]   B_EDGE = XY_W'(BULLET_SIZE - 1);

   // Sprites are packed back to back: player1, player2, bullet1, bullet2.
   localparam logic [ADDR_W-1:0] BASE_P1 = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] BASE_P2 = ADDR_W'(BASE_ADDR + P_PIX);
   localparam logic [ADDR_W-1:0] BASE_B1 = ADDR_W'(BASE_ADDR + 2*P_PIX);
   localparam logic [ADDR_W-1:0] BASE_B2 = ADDR_W'(BASE_ADDR + 2*P_PIX + B_PIX);

   state_t              state_q, state_d;
   logic [1:0]          obj_q, obj_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [XY_W-1:0]     h_q, h_d;
   logic [XY_W-1:0]     v_q, v_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                opa_q, opa_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                ready_q, ready_d;
   logic                wr_q, wr_d;

   logic [ADDR_W-1:0]   obj_base;
   logic [CNT_W-1:0]    last_cnt;
   logic [XY_W-1:0]     last_col;
   logic [DATA_W-1:0]   pix565;
   logic                unused_color_lsbs;

   // Truncated colour bits are intentionally dropped by the RGB565 packing.
   assign unused_color_lsbs = ^{i_src_color[18:16], i_src_color[9:8], i_src_color[2:0]};
   assign pix565 = DATA_W'({i_src_color[23:19], i_src_color[15:10], i_src_color[7:3]});

   // Per-object geometry: base address, last pixel index and last column.
   always_comb begin
      obj_base = BASE_P1;
      case (obj_q)
         2'd0: obj_base = BASE_P1;
         2'd1: obj_base = BASE_P2;
         2'd2: obj_base = BASE_B1;
         2'd3: obj_base = BASE_B2;
         default: obj_base = BASE_P1;
      endcase
      last_cnt = obj_q[1] ? B_LAST : P_LAST;
      last_col = obj_q[1] ? B_EDGE : P_EDGE;
   end

   // Next-state logic; row/column advance incrementally alongside the pixel index.
   always_comb begin
      state_d = state_q;
      obj_d   = obj_q;
      cnt_d   = cnt_q;
      h_d     = h_q;
      v_d     = v_q;
      addr_d  = addr_q;
      data_d  = data_q;
      opa_d   = opa_q;
      case (state_q)
         IDLE: begin
            if (i_start) begin
               obj_d   = 2'd0;
               cnt_d   = '0;
               h_d     = '0;
               v_d     = '0;
               state_d = FETCH;
            end
         end
         FETCH: begin
            if (i_src_valid) begin
               data_d  = pix565;
               opa_d   = i_src_alpha;
               addr_d  = obj_base + ADDR_W'(cnt_q);
               state_d = WRITE;
            end
         end
         WRITE: begin
            if (cnt_q == last_cnt) begin
               obj_d   = obj_q + 2'd1;
               cnt_d   = '0;
               h_d     = '0;
               v_d     = '0;
               state_d = (obj_q == 2'd3) ? DONE : FETCH;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
               state_d = FETCH;
               if (h_q == last_col) begin
                  h_d = '0;
                  v_d = v_q + XY_W'(1);
               end else begin
                  h_d = h_q + XY_W'(1);
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Strobes are registered: decode them from the state being entered.
      ready_d = (state_d == FETCH);
      wr_d    = (state_d == WRITE);
      done_d  = (state_d == DONE);
      busy_d  = (state_d == FETCH) || (state_d == WRITE);
   end

   // State and output registers; reset aborts any encode with no done pulse.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         obj_q   <= '0;
         cnt_q   <= '0;
         h_q     <= '0;
         v_q     <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         opa_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ready_q <= 1'b0;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         obj_q   <= obj_d;
         cnt_q   <= cnt_d;
         h_q     <= h_d;
         v_q     <= v_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         opa_q   <= opa_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ready_q <= ready_d;
         wr_q    <= wr_d;
      end
   end

   assign o_busy                = busy_q;
   assign o_done                = done_q;
   assign o_object_id           = obj_q;
   assign o_pixel_counter       = cnt_q;
   assign o_pixel_h             = h_q;
   assign o_pixel_v             = v_q;
   assign o_src_ready           = ready_q;
   assign o_sram_writing        = wr_q;
   assign o_sram_addr           = addr_q;
   assign o_sram_data           = data_q;
   assign o_pixel_opacity       = opa_q;
   assign o_pixel_opacity_valid = wr_q;

endmodule

// File: tb/tb_frame_encoder.sv
// tb_frame_encoder: scoreboard bench. The source process pushes the expected
// write for every accepted pixel; the monitor pops and compares on each write.
`timescale 1ns/1ps
module tb_frame_encoder;
   localparam int AW = 20;
   localparam int DW = 16;
   localparam int CW = 10;
   localparam int XW = 5;
   localparam int NPIX = 2176;

   logic          i_clk = 1'b0;
   logic          i_rst_n;
   logic          i_start;
   logic          o_busy, o_done;
   logic [1:0]    o_object_id;
   logic [CW-1:0] o_pixel_counter;
   logic [XW-1:0] o_pixel_h, o_pixel_v;
   logic          o_src_ready;
   logic          i_src_valid;
   logic [23:0]   i_src_color;
   logic          i_src_alpha;
   logic          o_sram_writing;
   logic [AW-1:0] o_sram_addr;
   logic [DW-1:0] o_sram_data;
   logic          o_pixel_opacity, o_pixel_opacity_valid;

   always #5 i_clk = ~i_clk;

   frame_encoder dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start),
      .o_busy(o_busy), .o_done(o_done), .o_object_id(o_object_id),
      .o_pixel_counter(o_pixel_counter), .o_pixel_h(o_pixel_h), .o_pixel_v(o_pixel_v),
      .o_src_ready(o_src_ready), .i_src_valid(i_src_valid),
      .i_src_color(i_src_color), .i_src_alpha(i_src_alpha),
      .o_sram_writing(o_sram_writing), .o_sram_addr(o_sram_addr),
      .o_sram_data(o_sram_data), .o_pixel_opacity(o_pixel_opacity),
      .o_pixel_opacity_valid(o_pixel_opacity_valid)
   );

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          opa;
      logic [1:0]    obj;
      logic [CW-1:0] cnt;
      logic [XW-1:0] h;
      logic [XW-1:0] v;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   g = 0;
   int   nwrites = 0;
   int   ndones = 0;
   bit   src_en = 1'b0;
   int   stall_at = -1;
   int   stall_left = 0;

   function automatic logic [23:0] color_of(int gi);
      if (gi == 0) return 24'hFF8040;
      return {8'(gi), 8'(gi >> 8) ^ 8'hA5, 8'(gi * 7)};
   endfunction

   function automatic logic alpha_of(int gi);
      logic [31:0] u;
      u = gi;
      return ~(u[0] & u[2]);
   endfunction

   // Reference: global pixel index -> sprite, offset, row/column, address, data.
   function automatic exp_t model(int gi);
      exp_t e;
      int obj, cnt, sz, base;
      logic [23:0] c;
      if (gi < 1024)      begin obj = 0; cnt = gi;        sz = 32; base = 0;    end
      else if (gi < 2048) begin obj = 1; cnt = gi - 1024; sz = 32; base = 1024; end
      else if (gi < 2112) begin obj = 2; cnt = gi - 2048; sz = 8;  base = 2048; end
      else                begin obj = 3; cnt = gi - 2112; sz = 8;  base = 2112; end
      c = color_of(gi);
      e.addr = AW'(base + cnt);
      e.data = {c[23:19], c[15:10], c[7:3]};
      e.opa  = alpha_of(gi);
      e.obj  = 2'(obj);
      e.cnt  = CW'(cnt);
      e.h    = XW'(cnt % sz);
      e.v    = XW'(cnt / sz);
      return e;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] outs();
      return {o_busy, o_done, o_object_id, o_pixel_counter, o_pixel_h, o_pixel_v,
              o_src_ready, o_sram_writing, o_sram_addr, o_sram_data,
              o_pixel_opacity, o_pixel_opacity_valid};
   endfunction

   // Pixel source: drives at negedge; a handshake seen here completes on the next posedge.
   initial begin
      bit stalling;
      stalling    = 1'b0;
      i_src_valid = 1'b0;
      i_src_color = '0;
      i_src_alpha = 1'b0;
      forever begin
         @(negedge i_clk);
         if (g == stall_at && stall_left > 0 && (o_src_ready || stalling)) begin
            stalling    = 1'b1;
            i_src_valid = 1'b0;
            stall_left--;
            check("stall_ready_held", 64'(o_src_ready), 64'd1);
            check("stall_counter_frozen", 64'(o_pixel_counter), 64'(model(g).cnt));
            check("stall_no_write", 64'(o_sram_writing), 64'd0);
         end else begin
            stalling    = 1'b0;
            i_src_valid = src_en;
         end
         i_src_color = color_of(g);
         i_src_alpha = alpha_of(g);
         if (i_src_valid && o_src_ready) begin
            sb.push_back(model(g));
            g++;
         end
      end
   end

   // Monitor: compares every write against the oldest pending expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge i_clk);
         if (o_done) begin
            ndones++;
            check("done_busy_low", 64'(o_busy), 64'd0);
         end
         if (o_sram_writing) begin
            nwrites++;
            if (sb.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_write: addr 0x%0h with no pending pixel", o_sram_addr);
            end else begin
               e = sb.pop_front();
               check("write_pixel",
                     64'({o_sram_addr, o_sram_data, o_pixel_opacity, o_object_id,
                          o_pixel_counter, o_pixel_h, o_pixel_v}), 64'(e));
               check("opacity_valid", 64'(o_pixel_opacity_valid), 64'd1);
               if (o_sram_addr == 20'd0)
                  check("p1_pix0_data", 64'({o_sram_data, o_pixel_opacity}), 64'({16'hFC08, 1'b1}));
               if (o_sram_addr == 20'd33)
                  check("p1_pix33_hv", 64'({o_pixel_h, o_pixel_v}), 64'({5'd1, 5'd1}));
               if (o_sram_addr == 20'd2048)
                  check("b1_first", 64'({o_object_id, o_pixel_h, o_pixel_v, o_pixel_counter}),
                        64'({2'd2, 5'd0, 5'd0, 10'd0}));
               if (o_sram_addr == 20'd2175)
                  check("b2_last", 64'({o_object_id, o_pixel_h, o_pixel_v}), 64'({2'd3, 5'd7, 5'd7}));
            end
         end else if (o_pixel_opacity_valid) begin
            n_cmp++;
            n_bad++;
            $display("FAIL opacity_valid_outside_write: got 1, want 0");
         end
      end
   end

   // One full encode; cycle count includes the start cycle and the done cycle.
   task automatic run(input string tag, input int stall_g, input int exp_cyc, input bit poke);
      int cyc;
      bit got;
      g          = 0;
      stall_at   = stall_g;
      stall_left = (stall_g >= 0) ? 5 : 0;
      nwrites    = 0;
      ndones     = 0;
      src_en     = 1'b1;
      sb.delete();
      i_start = 1'b1;
      cyc = 1;
      got = 1'b0;
      @(negedge i_clk);
      i_start = 1'b0;
      cyc = 2;
      check({tag, "_start_ready"}, 64'({o_busy, o_src_ready}), 64'({1'b1, 1'b1}));
      while (!got && cyc < exp_cyc + 50) begin
         @(negedge i_clk);
         cyc++;
         i_start = (poke && cyc == 300);
         if (o_done) got = 1'b1;
      end
      i_start = 1'b0;
      if (!got) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s_done_timeout: no done after %0d cycles, want %0d", tag, cyc, exp_cyc);
      end else begin
         check({tag, "_done_cycle"}, 64'(cyc), 64'(exp_cyc));
      end
      @(negedge i_clk);
      check({tag, "_write_count"}, 64'(nwrites), 64'(NPIX));
      check({tag, "_done_count"}, 64'(ndones), 64'd1);
      check({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
   endtask

   initial begin
      int cyc;
      int dones_before;
      i_rst_n = 1'b0;
      i_start = 1'b0;
      repeat (3) @(negedge i_clk);
      check("reset_state", outs(), 64'd0);
      i_rst_n = 1'b1;
      repeat (3) @(negedge i_clk);
      check("idle_after_reset", outs(), 64'd0);

      // Back-to-back source, minimum duration 2*2176+2.
      run("run1", -1, 4354, 1'b0);
      repeat (4) @(negedge i_clk);
      check("idle_after_done", 64'({o_busy, o_src_ready, o_sram_writing}), 64'd0);

      // Restart from IDLE, 5-cycle stall at pixel 40, ignored start while busy.
      run("run2", 40, 4359, 1'b1);
      repeat (4) @(negedge i_clk);

      // Abort with reset while player2 is being written.
      g = 0;
      stall_at = -1;
      stall_left = 0;
      sb.delete();
      i_start = 1'b1;
      @(negedge i_clk);
      i_start = 1'b0;
      cyc = 0;
      while (!(o_object_id == 2'd1 && o_pixel_counter == 10'd10) && cyc < 4000) begin
         @(negedge i_clk);
         cyc++;
      end
      check("reach_player2", 64'({o_object_id, o_pixel_counter}), 64'({2'd1, 10'd10}));
      dones_before = ndones;
      #2 i_rst_n = 1'b0;
      #1 check("async_reset_outputs", outs(), 64'd0);
      repeat (3) @(negedge i_clk);
      sb.delete();
      i_rst_n = 1'b1;
      repeat (20) @(negedge i_clk);
      check("no_done_after_abort", 64'(ndones), 64'(dones_before));
      check("idle_after_abort", outs(), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      n_bad++;
      $display("FAIL watchdog: simulation did not finish in time");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog");
   end

endmodule
